// File: rtl/instr_fetch_issue_pkg.sv
// Shared constants for the fetch/issue front end: opcodes, FSM encoding, field offsets.
package instr_fetch_issue_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'd0;
   localparam logic [5:0] OP_LW     = 6'd1;
   localparam logic [5:0] OP_SW     = 6'd2;
   localparam logic [5:0] OP_BRANCH = 6'd3;

   localparam logic [0:0] FETCH = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   localparam int unsigned OPCODE_MSB = 31;
   localparam int unsigned OPCODE_LSB = 26;

   function automatic logic [5:0] get_opcode(input logic [31:0] instr);
      return instr[OPCODE_MSB:OPCODE_LSB];
   endfunction

endpackage

// File: rtl/instr_fetch_issue_pc_next_calc.sv
// Combinational next-PC: sequential step plus optional sign-extended word offset.
module pc_next_calc
   import instr_fetch_issue_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned PC_STEP = 4
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic              taken,
   input  logic [15:0]       imm,
   output logic [ADDR_W-1:0] next_pc
);

   logic [ADDR_W-1:0] offset;

   always_comb begin
      offset = '0;
      // Immediate counts words, so scale to bytes after sign extension.
      if (taken) offset = {{(ADDR_W-16){imm[15]}}, imm} << 2;
      next_pc = pc + ADDR_W'(PC_STEP) + offset;
   end

endmodule

// File: rtl/instr_fetch_issue.sv
// Two-state fetch/issue front end: fetches one word, presents it, then advances the PC.
module instr_fetch_issue
   import instr_fetch_issue_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   output logic              issue_valid,
   input  logic              issue_ready,
   output logic [31:0]       issue_instr,
   output logic [5:0]        opcode,
   output logic [ADDR_W-1:0] issue_pc,
   input  logic              branch_taken,
   input  logic [15:0]       branch_imm,
   output logic [31:0]       issued_count
);

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
   logic              req_q, req_d;
   logic              valid_q, valid_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic [31:0]       cnt_q, cnt_d;

   pc_next_calc #(
      .ADDR_W  (ADDR_W),
      .PC_STEP (PC_STEP)
   ) u_pc_next_calc (
      .pc      (pc_q),
      .taken   (branch_taken),
      .imm     (branch_imm),
      .next_pc (next_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      valid_d = valid_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      cnt_d   = cnt_q;
      if (state_q == FETCH) begin
         // Request is idle only in the first cycle after reset.
         if (!req_q) begin
            req_d = 1'b1;
         end else if (imem_ready) begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            req_d   = 1'b0;
            valid_d = 1'b1;
            state_d = ISSUE;
         end
      end else begin
         if (issue_ready) begin
            pc_d    = next_pc;
            cnt_d   = cnt_q + 32'd1;
            valid_d = 1'b0;
            // Re-request immediately so back-to-back throughput is one per 2 cycles.
            req_d   = 1'b1;
            state_d = FETCH;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= '0;
         ipc_q   <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign issue_valid  = valid_q;
   assign issue_instr  = instr_q;
   assign opcode       = get_opcode(instr_q);
   assign issue_pc     = ipc_q;
   assign issued_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue with a fetch/issue scoreboard.
module tb_instr_fetch_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ready, issue_valid, issue_ready, branch_taken;
   logic [31:0] imem_addr, imem_rdata, issue_instr, issue_pc, issued_count;
   logic [5:0]  opcode;
   logic [15:0] branch_imm;

   logic        w_imem_req, w_imem_ready, w_issue_valid, w_issue_ready, w_taken;
   logic [31:0] w_imem_addr, w_imem_rdata, w_issue_instr, w_issue_pc, w_issued_count;
   logic [5:0]  w_opcode;
   logic [15:0] w_imm;

   always #5 clk = ~clk;

   instr_fetch_issue dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_instr(issue_instr), .opcode(opcode),
      .issue_pc(issue_pc), .branch_taken(branch_taken), .branch_imm(branch_imm),
      .issued_count(issued_count)
   );

   instr_fetch_issue #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
      .imem_ready(w_imem_ready), .imem_rdata(w_imem_rdata), .issue_valid(w_issue_valid),
      .issue_ready(w_issue_ready), .issue_instr(w_issue_instr), .opcode(w_opcode),
      .issue_pc(w_issue_pc), .branch_taken(w_taken), .branch_imm(w_imm),
      .issued_count(w_issued_count)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_count;
   int          total = 0;
   int          bad = 0;

   // Reference model: push on fetch handshake, pop and advance PC on issue handshake.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'd0;
         m_count = 32'd0;
         exp_q.delete();
      end else begin
         if (imem_req && imem_ready) exp_q.push_back({m_pc, imem_rdata});
         if (issue_valid && issue_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            m_pc = m_pc + 32'd4 +
                   (branch_taken ? {{14{branch_imm[15]}}, branch_imm, 2'b00} : 32'd0);
            m_count = m_count + 32'd1;
         end
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic clear_inputs;
      imem_ready = 0; imem_rdata = 0; issue_ready = 0; branch_taken = 0; branch_imm = 0;
      w_imem_ready = 0; w_imem_rdata = 0; w_issue_ready = 0; w_taken = 0; w_imm = 0;
   endtask

   task automatic do_reset;
      rst_n = 0;
      clear_inputs();
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   // Fetch one word then issue it with the given branch inputs; ends in FETCH.
   task automatic run_one(input logic [31:0] rd, input logic tk, input logic [15:0] imm);
      imem_rdata = rd; imem_ready = 1; issue_ready = 0;
      tick();
      imem_ready = 0; issue_ready = 1; branch_taken = tk; branch_imm = imm;
      tick();
      issue_ready = 0; branch_taken = 0; branch_imm = 0;
   endtask

   task automatic test_reset;
      rst_n = 0;
      clear_inputs();
      tick(); tick();
      total++; if (imem_req !== 1'b0) begin bad++;
         $display("FAIL reset_req: got %b want 0", imem_req); end
      total++; if (issue_valid !== 1'b0) begin bad++;
         $display("FAIL reset_valid: got %b want 0", issue_valid); end
      total++; if (issue_instr !== 32'd0 || opcode !== 6'd0) begin bad++;
         $display("FAIL reset_instr: got %h/%h want 0/0", issue_instr, opcode); end
      total++; if (issue_pc !== 32'd0 || imem_addr !== 32'd0) begin bad++;
         $display("FAIL reset_pc: got %h/%h want 0/0", issue_pc, imem_addr); end
      total++; if (issued_count !== 32'd0) begin bad++;
         $display("FAIL reset_count: got %0d want 0", issued_count); end
      total++; if (w_issue_pc !== 32'hFFFF_FFFC || w_imem_addr !== 32'hFFFF_FFFC) begin bad++;
         $display("FAIL reset_wrap_pc: got %h/%h want fffffffc", w_issue_pc, w_imem_addr); end
      rst_n = 1;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin bad++;
         $display("FAIL reset_first_req: got %b@%h want 1@0", imem_req, imem_addr); end
   endtask

   task automatic test_stream;
      imem_ready = 1; issue_ready = 1; imem_rdata = 32'd0;
      for (int i = 0; i < 8; i++) begin
         total++; if (issue_valid !== (i % 2 == 1) || imem_req !== (i % 2 == 0)) begin bad++;
            $display("FAIL stream_phase%0d: got v=%b r=%b want v=%b", i, issue_valid, imem_req,
                     (i % 2 == 1)); end
         if (i % 2 == 0) begin
            total++; if (imem_addr !== 32'(4 * (i / 2)) || imem_addr !== m_pc) begin bad++;
               $display("FAIL stream_addr%0d: got %h want %h", i, imem_addr, 32'(4 * (i / 2)));
            end
         end else begin
            total++;
            if (exp_q.size() == 0) begin bad++;
               $display("FAIL stream_issue%0d: got valid with empty scoreboard want entry", i);
            end else if (issue_pc !== exp_q[0].pc || issue_instr !== exp_q[0].instr) begin bad++;
               $display("FAIL stream_issue%0d: got %h/%h want %h/%h", i, issue_pc, issue_instr,
                        exp_q[0].pc, exp_q[0].instr);
            end
         end
         tick();
      end
      total++; if (issued_count !== 32'd4 || issued_count !== m_count) begin bad++;
         $display("FAIL stream_count: got %0d want 4", issued_count); end
      clear_inputs();
   endtask

   task automatic test_hold;
      do_reset();
      imem_rdata = 32'h0400_0000; imem_ready = 1; issue_ready = 0;
      tick();
      // imem_ready stays high to confirm it is ignored while no request is out.
      for (int k = 0; k < 5; k++) begin
         total++; if (issue_valid !== 1'b1 || imem_req !== 1'b0) begin bad++;
            $display("FAIL hold_state%0d: got v=%b r=%b want v=1 r=0", k, issue_valid, imem_req);
         end
         total++; if (issue_instr !== 32'h0400_0000 || issue_pc !== 32'd0 || opcode !== 6'd1)
         begin bad++;
            $display("FAIL hold_data%0d: got %h/%h/%h want 04000000/0/01", k, issue_instr,
                     issue_pc, opcode);
         end
         imem_rdata = 32'hFFFF_0000 + 32'(k);
         tick();
      end
      imem_ready = 0; issue_ready = 1;
      tick();
      issue_ready = 0;
      total++; if (issue_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd4) begin bad++;
         $display("FAIL hold_release: got v=%b r=%b a=%h want 0/1/4", issue_valid, imem_req,
                  imem_addr); end
      total++; if (issued_count !== 32'd1) begin bad++;
         $display("FAIL hold_count: got %0d want 1", issued_count); end
   endtask

   task automatic test_branch;
      do_reset();
      for (int n = 0; n < 4; n++) run_one(32'd0, 1'b0, 16'h0000);
      total++; if (imem_addr !== 32'h10) begin bad++;
         $display("FAIL branch_start: got %h want 10", imem_addr); end
      run_one(32'h0C00_0000, 1'b1, 16'hFFFE);
      total++; if (imem_addr !== 32'h0C || imem_addr !== m_pc) begin bad++;
         $display("FAIL branch_back: got %h want 0c", imem_addr); end
      run_one(32'h0C00_0000, 1'b1, 16'h0003);
      total++; if (imem_addr !== 32'h1C || imem_addr !== m_pc) begin bad++;
         $display("FAIL branch_fwd: got %h want 1c", imem_addr); end
   endtask

   task automatic test_branch_ignored;
      branch_taken = 1; branch_imm = 16'h0100; imem_ready = 0;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin bad++;
         $display("FAIL ign_fetch: got r=%b a=%h want 1/1c", imem_req, imem_addr); end
      imem_ready = 1; imem_rdata = 32'h0000_0001;
      tick();
      imem_ready = 0;
      tick();
      total++; if (issue_valid !== 1'b1 || issue_pc !== 32'h1C) begin bad++;
         $display("FAIL ign_issue: got v=%b pc=%h want 1/1c", issue_valid, issue_pc); end
      issue_ready = 1; branch_taken = 0; branch_imm = 0;
      tick();
      issue_ready = 0;
      total++; if (imem_addr !== 32'h20 || imem_addr !== m_pc) begin bad++;
         $display("FAIL ign_next: got %h want 20", imem_addr); end
   endtask

   task automatic test_delay;
      imem_ready = 0;
      for (int k = 0; k < 3; k++) begin
         imem_rdata = $urandom;
         tick();
         total++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || issue_valid !== 1'b0)
         begin bad++;
            $display("FAIL delay_wait%0d: got r=%b a=%h v=%b want 1/20/0", k, imem_req,
                     imem_addr, issue_valid);
         end
      end
      imem_rdata = 32'h0C00_0123; imem_ready = 1;
      tick();
      imem_ready = 0; imem_rdata = 32'hFFFF_FFFF;
      total++;
      if (exp_q.size() == 0) begin bad++;
         $display("FAIL delay_latch: got empty scoreboard want entry"); end
      else if (issue_valid !== 1'b1 || issue_instr !== exp_q[0].instr ||
               issue_pc !== exp_q[0].pc || opcode !== 6'd3) begin bad++;
         $display("FAIL delay_latch: got %h@%h op=%h want 0c000123@20 op=03", issue_instr,
                  issue_pc, opcode);
      end
      issue_ready = 1;
      tick();
      issue_ready = 0;
      total++; if (imem_addr !== 32'h24) begin bad++;
         $display("FAIL delay_next: got %h want 24", imem_addr); end
   endtask

   task automatic test_wrap;
      w_imem_rdata = 32'h0800_0000; w_imem_ready = 1; w_issue_ready = 1;
      total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin bad++;
         $display("FAIL wrap_fetch: got r=%b a=%h want 1/fffffffc", w_imem_req, w_imem_addr); end
      tick();
      total++; if (w_issue_valid !== 1'b1 || w_issue_pc !== 32'hFFFF_FFFC || w_opcode !== 6'd2)
      begin bad++;
         $display("FAIL wrap_issue: got v=%b pc=%h op=%h want 1/fffffffc/02", w_issue_valid,
                  w_issue_pc, w_opcode);
      end
      tick();
      w_imem_ready = 0; w_issue_ready = 0;
      total++; if (w_imem_addr !== 32'd0 || w_issued_count !== 32'd1) begin bad++;
         $display("FAIL wrap_addr: got a=%h c=%0d want 0/1", w_imem_addr, w_issued_count); end
   endtask

   task automatic test_reset_mid;
      imem_rdata = 32'hFC00_0000; imem_ready = 1; issue_ready = 0;
      tick();
      imem_ready = 0;
      total++; if (issue_valid !== 1'b1 || opcode !== 6'h3F || issued_count === 32'd0) begin bad++;
         $display("FAIL mid_pre: got v=%b op=%h c=%0d want 1/3f/nonzero", issue_valid, opcode,
                  issued_count); end
      #2 rst_n = 0;
      #1;
      total++; if (issue_valid !== 1'b0 || imem_req !== 1'b0 || issue_instr !== 32'd0 ||
                   opcode !== 6'd0 || issue_pc !== 32'd0 || issued_count !== 32'd0) begin bad++;
         $display("FAIL mid_async: got v=%b r=%b i=%h op=%h pc=%h c=%0d want all 0",
                  issue_valid, imem_req, issue_instr, opcode, issue_pc, issued_count);
      end
      tick();
      rst_n = 1;
      tick();
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || issued_count !== 32'd0) begin bad++;
         $display("FAIL mid_restart: got r=%b a=%h c=%0d want 1/0/0", imem_req, imem_addr,
                  issued_count); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_hold();
      test_branch();
      test_branch_ignored();
      test_delay();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
